pipe_mem_reader: RTL

- Readback engine for the 256x16 result memory that the 4-stage ALU pipeline writes at stage 4.
- It sits on the memory read port and forms the consumer end of the pipeline's write-to-memory path.
- On a start command it issues sequential reads from a base address for a given word count.
- Returned words are streamed out on a valid/ready interface through a 2-entry output buffer, tagged with address and a last flag.

---
 rtl/pipe_mem_reader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/pipe_mem_reader.sv
// Readback engine for the ALU pipeline's result memory.
// On start it issues sequential reads (address wraps modulo 2**AW). Returned
// words are streamed through a 2-entry FIFO on a valid/ready interface, each
// tagged with its source address and a last flag. A credit check on buffer
// occupancy plus the read in flight guarantees returned data always has a slot.
module pipe_mem_reader #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_rd_addr,
  input  logic [DW-1:0] mem_rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last
);

  localparam logic [AW:0]   MAX_CNT  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   issued_q, issued_d;

  // Tag of the read whose data returns on the next edge.
  logic          infl_q;
  logic [AW-1:0] infl_addr_q;
  logic          infl_last_q;

  // Output FIFO storage.
  logic [DW-1:0] fdata_q [2];
  logic [AW-1:0] faddr_q [2];
  logic          flast_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    occ_q;

  logic          push, pop;
  logic [2:0]    outstanding;
  logic          issue_last;

  function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
    return (c > MAX_CNT) ? MAX_CNT : c;
  endfunction

  assign push        = infl_q;
  assign pop         = out_valid && out_ready;
  // Words already buffered plus the one in flight, minus the one leaving now.
  assign outstanding = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
  assign mem_rd_en   = (state_q == S_READ) && (outstanding < 3'd2);
  assign mem_rd_addr = addr_q;
  assign issue_last  = (issued_q == (cnt_q - CNT_ONE));

  assign busy        = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);

  assign out_valid   = (occ_q != 2'd0);
  assign out_data    = fdata_q[rd_ptr_q];
  assign out_addr    = faddr_q[rd_ptr_q];
  assign out_last    = flast_q[rd_ptr_q];

  // Next-state logic: command capture, read issue and completion tracking.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d   = base_addr;
            cnt_d    = clamp_count(count);
            issued_d = '0;
            state_d  = S_READ;
          end
        end
      end
      S_READ: begin
        if (mem_rd_en) begin
          addr_d   = addr_q + ADDR_ONE;
          issued_d = issued_q + CNT_ONE;
          if ((issued_q + CNT_ONE) == cnt_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop && out_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
    end
  end

  // Remember address and last tag of each issued read until its data returns.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      infl_q      <= mem_rd_en;
      infl_addr_q <= addr_q;
      infl_last_q <= issue_last;
    end
  end

  // Two-entry in-order FIFO; push is returned read data, pop is a downstream accept.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        fdata_q[i] <= '0;
        faddr_q[i] <= '0;
        flast_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) begin
        fdata_q[wr_ptr_q] <= mem_rd_data;
        faddr_q[wr_ptr_q] <= infl_addr_q;
        flast_q[wr_ptr_q] <= infl_last_q;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      occ_q <= occ_q + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
